// File: rtl/param_stream_fifo_pkg.sv
// Shared sizing helpers and limits for the typed-parameter stream FIFO.
package param_fifo_pkg;

  localparam int unsigned MAX_DEPTH = 256;

  function automatic int unsigned cnt_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(int unsigned depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/param_stream_fifo_ptr.sv
// Circular pointer over DEPTH entries; wraps by explicit compare so non-power-of-two depths work.
module fifo_wrap_ptr
  import param_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inc,
  input  logic                       clr,
  output logic [ptr_w(DEPTH)-1:0]    ptr
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/param_stream_fifo.sv
// Valid/ready FIFO with a type-parameterised element, arbitrary depth and an idle output value.
module param_stream_fifo
  import param_fifo_pkg::*;
#(
  parameter type         T           = logic [7:0],
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AFULL_LEVEL = DEPTH - 1,
  parameter T            IDLE_VALUE  = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  T                           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output T                           out_data,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       almost_full
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);

  if (DEPTH < 2 || DEPTH > MAX_DEPTH || AFULL_LEVEL == 0 || AFULL_LEVEL > DEPTH) begin : g_param_err
    $error("param_stream_fifo: illegal DEPTH or AFULL_LEVEL");
  end

  logic [CW-1:0] count_d, count_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  T              mem_q [DEPTH];

  // Flush drops any same-cycle push so storage is never written by it.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .clr   (flush),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .clr   (flush),
    .ptr   (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

  always_comb begin
    in_ready    = (count_q != CW'(DEPTH));
    out_valid   = (count_q != '0);
    almost_full = (count_q >= CW'(AFULL_LEVEL));
    count       = count_q;
    out_data    = IDLE_VALUE;
    if (out_valid) begin
      out_data = mem_q[rd_ptr];
    end
  end

endmodule

// File: tb/tb_param_stream_fifo.sv
// Directed and randomized checks of three FIFO configurations against queue-based models.
module tb_param_stream_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT a: 8-bit, depth 4, afull 3, idle 0
  logic a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_afull;
  logic [7:0] a_in_data = '0, a_out_data;
  logic [2:0] a_count;
  // DUT b: 8-bit, depth 3, afull 2, idle EE
  logic b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_afull;
  logic [7:0] b_in_data = '0, b_out_data;
  logic [1:0] b_count;
  // DUT c: 16-bit, depth 5, afull 2, idle DEAD
  logic c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_afull;
  logic [15:0] c_in_data = '0, c_out_data;
  logic [2:0] c_count;

  logic [7:0]  qa [$];
  logic [7:0]  qb [$];
  logic [15:0] qc [$];

  param_stream_fifo #(.T(logic [7:0]), .DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count), .almost_full(a_afull));

  param_stream_fifo #(.T(logic [7:0]), .DEPTH(3), .IDLE_VALUE(8'hEE)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count), .almost_full(b_afull));

  param_stream_fifo #(.T(logic [15:0]), .DEPTH(5), .AFULL_LEVEL(2), .IDLE_VALUE(16'hDEAD)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .count(c_count), .almost_full(c_afull));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_count",     32'(a_count),     32'(qa.size()));
    chk("a_in_ready",  32'(a_in_ready),  32'(qa.size() != 4));
    chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
    chk("a_out_data",  32'(a_out_data),  32'((qa.size() != 0) ? qa[0] : 8'h00));
    chk("a_afull",     32'(a_afull),     32'(qa.size() >= 3));
    chk("b_count",     32'(b_count),     32'(qb.size()));
    chk("b_in_ready",  32'(b_in_ready),  32'(qb.size() != 3));
    chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
    chk("b_out_data",  32'(b_out_data),  32'((qb.size() != 0) ? qb[0] : 8'hEE));
    chk("b_afull",     32'(b_afull),     32'(qb.size() >= 2));
    chk("c_count",     32'(c_count),     32'(qc.size()));
    chk("c_in_ready",  32'(c_in_ready),  32'(qc.size() != 5));
    chk("c_out_valid", 32'(c_out_valid), 32'(qc.size() != 0));
    chk("c_out_data",  32'(c_out_data),  32'((qc.size() != 0) ? qc[0] : 16'hDEAD));
    chk("c_afull",     32'(c_afull),     32'(qc.size() >= 2));
  endtask

  // One clock: models apply the same rules the FIFO must obey, then outputs are compared.
  task automatic step();
    bit do_pop, do_push;
    @(posedge clk);
    if (!rst_n) begin
      qa.delete(); qb.delete(); qc.delete();
    end else begin
      if (a_flush) qa.delete();
      else begin
        do_pop = (qa.size() != 0) && a_out_ready;
        do_push = a_in_valid && (qa.size() != 4);
        if (do_pop) qa.delete(0);
        if (do_push) qa.push_back(a_in_data);
      end
      if (b_flush) qb.delete();
      else begin
        do_pop = (qb.size() != 0) && b_out_ready;
        do_push = b_in_valid && (qb.size() != 3);
        if (do_pop) qb.delete(0);
        if (do_push) qb.push_back(b_in_data);
      end
      if (c_flush) qc.delete();
      else begin
        do_pop = (qc.size() != 0) && c_out_ready;
        do_push = c_in_valid && (qc.size() != 5);
        if (do_pop) qc.delete(0);
        if (do_push) qc.push_back(c_in_data);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_all();
    a_flush = 0; a_in_valid = 0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0;
    c_flush = 0; c_in_valid = 0; c_out_ready = 0;
  endtask

  initial begin
    logic [7:0] seq_a [4];
    seq_a[0] = 8'h11; seq_a[1] = 8'h22; seq_a[2] = 8'h33; seq_a[3] = 8'h44;

    // Reset values
    step();
    step();
    rst_n = 1'b1;
    step();

    // Fill depth-4 FIFO with consumer stalled, then drain in order
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1; a_in_data = seq_a[i];
      step();
    end
    a_in_data = 8'h55;
    step();
    a_in_valid = 0; a_out_ready = 1;
    for (int i = 0; i < 5; i++) step();
    a_out_ready = 0;

    // Full with simultaneous push attempt: pop only, pushed value enters once space opens
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1; a_in_data = 8'h60 + 8'(i);
      step();
    end
    a_in_data = 8'h77; a_out_ready = 1;
    step();
    step();
    a_in_valid = 0;
    for (int i = 0; i < 5; i++) step();
    a_out_ready = 0;

    // Depth-3 streaming across pointer wrap
    b_in_valid = 1; b_out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      b_in_data = 8'(i);
      step();
    end
    b_in_valid = 0;
    step();
    step();
    b_out_ready = 0;

    // Flush with concurrent push and pop
    a_in_valid = 1;
    a_in_data = 8'h81; step();
    a_in_data = 8'h82; step();
    a_flush = 1; a_in_data = 8'h99; a_out_ready = 1;
    step();
    idle_all();
    a_out_ready = 1;
    step();
    step();
    idle_all();

    // Asynchronous reset mid-cycle with three elements held
    a_in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      a_in_data = 8'hC0 + 8'(i);
      step();
    end
    a_in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    qa.delete(); qb.delete(); qc.delete();
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    a_in_valid = 1; a_in_data = 8'hA5;
    step();
    a_in_valid = 0;
    step();
    a_out_ready = 1;
    step();
    a_out_ready = 0;

    // Wide element with non-zero idle value
    c_in_valid = 1; c_in_data = 16'h1234;
    step();
    c_in_valid = 0; c_out_ready = 1;
    step();
    step();
    c_out_ready = 0;

    // Randomized traffic on all three instances
    for (int n = 0; n < 300; n++) begin
      a_in_valid = 1'($urandom); a_out_ready = 1'($urandom); a_in_data = 8'($urandom);
      a_flush = ($urandom_range(0, 19) == 0);
      b_in_valid = 1'($urandom); b_out_ready = 1'($urandom); b_in_data = 8'($urandom);
      b_flush = ($urandom_range(0, 19) == 0);
      c_in_valid = ($urandom_range(0, 3) != 0); c_out_ready = 1'($urandom);
      c_in_data = 16'($urandom);
      c_flush = ($urandom_range(0, 29) == 0);
      step();
    end
    idle_all();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_stream_fifo.md
# param_stream_fifo

Synchronous valid/ready FIFO whose element type, depth, threshold and idle output value are all set through typed parameter ports (a `type` parameter, `int unsigned` scalars and a `T`-typed default). It buffers a stream between a producer stage and the consumer that follows it, absorbing consumer back-pressure of up to DEPTH elements. It also serves as the synthesizable consumer of the team's typed-parameter declaration forms: type parameters, implied-type defaults and non-power-of-two depths.

## Interface
- T, logic [7:0], element type (type parameter)
- DEPTH, 4, number of storage entries; int unsigned, legal range 2..256, need not be a power of two
- AFULL_LEVEL, DEPTH-1, count at or above which almost_full asserts; int unsigned, legal range 1..DEPTH
- IDLE_VALUE, '0, value of type T driven on out_data while the FIFO is empty
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous clear of contents
- in_valid  in  1  producer has data
- in_ready  out  1  FIFO accepts data this cycle
- in_data  in  $bits(T)  producer element
- out_valid  out  1  head element valid
- out_ready  in  1  consumer accepts head
- out_data  out  $bits(T)  head element, or IDLE_VALUE when empty
- count  out  $clog2(DEPTH+1)  current occupancy
- almost_full  out  1  count >= AFULL_LEVEL

## Operation
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready.
- out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid, else IDLE_VALUE.
- Pointers wr_ptr and rd_ptr use $clog2(DEPTH) bits each and wrap from DEPTH-1 to 0 by explicit compare, not by natural overflow.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. A simultaneous push and pop is legal whenever 0 < count < DEPTH.
- Full (count == DEPTH): in_ready = 0, so a pop-only cycle occurs. There is no write-through of new data.
- Empty (count == 0): no pop is possible. A push makes the element visible on out_data in the next cycle (no bypass).
- flush takes priority over push and pop in the same cycle. Pointers and count go to 0 at the next edge, and the in-flight push is dropped. Storage contents are not cleared.
- Data order is strict FIFO. Storage mem[0:DEPTH-1] of type T has no reset and is written only on push.

## Timing
- Reset (rst_n low, asynchronous): wr_ptr = rd_ptr = 0, count = 0. Outputs: in_ready = 1, out_valid = 0, out_data = IDLE_VALUE, count = 0, almost_full = 0.
- Reset deasserting mid-stream discards all contents. The first cycle after deassertion behaves as empty.
- Latency from push to visibility on out_valid is 1 cycle. Throughput is 1 element/cycle sustained with out_ready held high.
- almost_full and count are registered-state decodes, valid in the same cycle as in_ready.
- Elaboration check: $error if DEPTH < 2, or if AFULL_LEVEL is 0 or greater than DEPTH.

## Structure
- Package param_fifo_pkg holds:
  - function cnt_w(int unsigned depth) returning $clog2(depth+1)
  - function ptr_w(int unsigned depth) returning max(1, $clog2(depth))
  - localparam int unsigned MAX_DEPTH = 256
- Sub-module fifo_wrap_ptr holds one pointer: parameter DEPTH, inputs clk, rst_n, inc and clr, output ptr. It is instanced once for wr_ptr and once for rd_ptr.
- The top level holds storage, count, and flags.

## Test plan
- Reset, then push 0x11, 0x22, 0x33, 0x44 with out_ready = 0 and DEPTH = 4 → count = 4, in_ready = 0, almost_full from count = 3. Then pop 4 with out_ready = 1 → out_data reads 0x11, 0x22, 0x33, 0x44 in order, then IDLE_VALUE.
- DEPTH = 3, continuous push and pop of 0..9 → output order is 0..9, count stays at 1, and pointers wrap 2→0 with no gap.
- Full (count = 4) with in_valid = 1 and out_ready = 1 → only a pop occurs, count = 3, and the pushed value appears only after in_ready returns.
- count = 2, flush = 1 together with in_valid = 1 and out_ready = 1 → next cycle count = 0, out_valid = 0, out_data = IDLE_VALUE, and the pushed element never emerges.
- rst_n pulled low asynchronously mid-cycle with count = 3 → outputs reach reset values before the next clock edge. After release, a push of 0xA5 appears one cycle later as the sole element.
- T = logic [15:0], IDLE_VALUE = 16'hDEAD → out_data reads 16'hDEAD when empty, and a push of 16'h1234 reads back unchanged.
